// File: rtl/freq_gate_counter.sv
// Gated frequency counter: counts synchronised rising edges of sigdin over a fixed
// window of GATE_CYCLES clocks and latches the 4-digit BCD result plus overflow/range flags.
module freq_gate_counter #(
   parameter int GATE_CYCLES = 50000000,
   parameter int GATE_W      = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sigdin,
   input  logic        SW2,
   output logic [15:0] bcd,
   output logic        ovf,
   output logic        range,
   output logic        valid
);

   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

   typedef enum logic [1:0] {
      COUNT = 2'd0,
      LATCH = 2'd1,
      CLEAR = 2'd2
   } state_t;

   state_t              state_reg;
   state_t              state_next;
   logic [GATE_W-1:0]   gate_reg;
   logic                s1_reg;
   logic                s2_reg;
   logic                s3_reg;
   logic                sig_edge;
   logic [15:0]         count_reg;
   logic [15:0]         count_inc;
   logic [4:0]          carry;
   logic                count_full;
   logic                ovf_int_reg;
   logic                range_int_reg;

   // s1/s2 resolve metastability; s3 delays s2 by one cycle for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_reg <= 1'b0;
         s2_reg <= 1'b0;
         s3_reg <= 1'b0;
      end else begin
         s1_reg <= sigdin;
         s2_reg <= s1_reg;
         s3_reg <= s2_reg;
      end
   end

   assign sig_edge = s2_reg & ~s3_reg;

   // Cascaded decade increment: a digit rolls 9->0 and passes the carry upward
   assign carry[0] = 1'b1;
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         logic [3:0] digit;
         assign digit          = count_reg[4*gi +: 4];
         assign carry[gi+1]    = carry[gi] & (digit == 4'd9);
         assign count_inc[4*gi +: 4] = !carry[gi]     ? digit :
                                       (digit == 4'd9) ? 4'd0  : digit + 4'd1;
      end
   endgenerate

   assign count_full = (count_reg == 16'h9999);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         COUNT:   if (gate_reg == GATE_LAST) state_next = LATCH;
         LATCH:   state_next = CLEAR;
         CLEAR:   state_next = COUNT;
         default: state_next = COUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= COUNT;
         gate_reg      <= '0;
         count_reg     <= 16'h0000;
         ovf_int_reg   <= 1'b0;
         range_int_reg <= SW2;
         bcd           <= 16'h0000;
         ovf           <= 1'b0;
         range         <= 1'b0;
         valid         <= 1'b0;
      end else begin
         state_reg <= state_next;
         valid     <= 1'b0;
         case (state_reg)
            COUNT: begin
               gate_reg <= gate_reg + 1'b1;
               if (sig_edge) begin
                  if (count_full) ovf_int_reg <= 1'b1;
                  else            count_reg   <= count_inc;
               end
            end
            LATCH: begin
               bcd   <= count_reg;
               ovf   <= ovf_int_reg;
               range <= range_int_reg;
               valid <= 1'b1;
            end
            CLEAR: begin
               count_reg     <= 16'h0000;
               ovf_int_reg   <= 1'b0;
               gate_reg      <= '0;
               range_int_reg <= SW2;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Scoreboard bench: a short-gate instance under random stimulus against an edge-counting
// model, plus a 20000-cycle instance for the overflow and BCD carry cases.
module tb_freq_gate_counter;

   localparam int G1 = 100;
   localparam int P1 = G1 + 2;
   localparam int G2 = 20000;
   localparam int P2 = G2 + 2;

   typedef struct {
      logic [15:0] bcd;
      logic        ovf;
      logic        rng;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sigdin = 1'b0;
   logic        sw2 = 1'b0;
   logic [15:0] bcd;
   logic        ovf;
   logic        range_o;
   logic        valid;

   logic        rst2 = 1'b1;
   logic        sigdin2 = 1'b0;
   logic        sw2b = 1'b0;
   logic [15:0] bcd2;
   logic        ovf2;
   logic        range2;
   logic        valid2;

   int   total = 0;
   int   bad = 0;
   exp_t q1[$];
   exp_t q2[$];
   logic rst_last = 1'b1;
   logic rst2_last = 1'b1;

   // model state: m_n is the index of the next clock edge since reset release
   int   m_n = 0;
   int   m_cnt = 0;
   logic m_rng = 1'b0;
   logic h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

   always #5 clk = ~clk;

   freq_gate_counter #(.GATE_CYCLES(G1), .GATE_W(8)) dut (
      .clk(clk), .rst(rst), .sigdin(sigdin), .SW2(sw2),
      .bcd(bcd), .ovf(ovf), .range(range_o), .valid(valid)
   );

   freq_gate_counter #(.GATE_CYCLES(G2), .GATE_W(15)) dut2 (
      .clk(clk), .rst(rst2), .sigdin(sigdin2), .SW2(sw2b),
      .bcd(bcd2), .ovf(ovf2), .range(range2), .valid(valid2)
   );

   function automatic exp_t make_exp(int edges, logic rng);
      exp_t e;
      int   v;
      v = (edges > 9999) ? 9999 : edges;
      e.bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      e.ovf = (edges > 9999);
      e.rng = rng;
      return e;
   endfunction

   function automatic logic is_bcd(logic [15:0] v);
      return (v[3:0] < 4'd10) && (v[7:4] < 4'd10) && (v[11:8] < 4'd10) && (v[15:12] < 4'd10);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // sigdin as seen by dut2 at edge m after reset release
   function automatic logic d2(int m);
      if (m >= 10 && m < 10 + 1230) return ((m - 10) % 10) < 5;
      if (m >= 20000 && m <= 39998) return (m % 2) == 0;
      return 1'b0;
   endfunction

   initial forever begin
      @(posedge clk);
      rst_last  = rst;
      rst2_last = rst2;
   end

   // Reference: an edge is the first clock the synchronised signal is seen high;
   // the gate is G1 counting clocks followed by a latch and a clear clock.
   initial forever begin
      int ph;
      @(posedge clk);
      if (rst) begin
         m_n = 0; m_cnt = 0; m_rng = sw2;
         h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      end else begin
         ph = m_n % P1;
         if (ph < G1 && h2 && !h3) m_cnt++;
         if (ph == G1) q1.push_back(make_exp(m_cnt, m_rng));
         if (ph == G1 + 1) begin
            m_cnt = 0;
            m_rng = sw2;
         end
         h3 = h2; h2 = h1; h1 = sigdin;
         m_n++;
      end
   end

   initial begin
      exp_t last = '{16'h0000, 1'b0, 1'b0};
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_last) begin
            chk("reset_outputs", {valid, bcd, ovf, range_o}, 19'h0);
            last = '{16'h0000, 1'b0, 1'b0};
         end else if (valid) begin
            if (q1.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               e = q1.pop_front();
               $display("gate: bcd=%h ovf=%0d range=%0d (exp %h/%0d/%0d)",
                        bcd, ovf, range_o, e.bcd, e.ovf, e.rng);
               chk("bcd", bcd, e.bcd);
               chk("ovf", ovf, e.ovf);
               chk("range", range_o, e.rng);
               chk("bcd_digits", is_bcd(bcd), 1);
               last = e;
            end
         end else begin
            chk("hold", {bcd, ovf, range_o}, {last.bcd, last.ovf, last.rng});
         end
      end
   end

   initial begin
      exp_t last = '{16'h0000, 1'b0, 1'b0};
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst2_last) begin
            chk("reset_outputs2", {valid2, bcd2, ovf2, range2}, 19'h0);
         end else if (valid2) begin
            if (q2.size() == 0) begin
               chk("unexpected_valid2", 1, 0);
            end else begin
               e = q2.pop_front();
               $display("gate2: bcd=%h ovf=%0d range=%0d (exp %h/%0d/%0d)",
                        bcd2, ovf2, range2, e.bcd, e.ovf, e.rng);
               chk("bcd2", bcd2, e.bcd);
               chk("ovf2", ovf2, e.ovf);
               chk("range2", range2, e.rng);
               chk("bcd2_digits", is_bcd(bcd2), 1);
               last = e;
            end
         end else begin
            chk("hold2", {bcd2, ovf2, range2}, {last.bcd, last.ovf, last.rng});
         end
      end
   end

   task automatic align1(int phase);
      for (int i = 0; i < P1 && (m_n % P1) != phase; i++) tick();
   endtask

   task automatic drive1();
      int mode;
      rst = 1'b1; sw2 = 1'b1; sigdin = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      repeat (2 * P1) tick();
      // seven clean pulses well inside one gate
      align1(5);
      repeat (7) begin
         sigdin = 1'b1; repeat (5) tick();
         sigdin = 1'b0; repeat (5) tick();
      end
      // range captured at clear; mid-gate change shows only on the next gate
      sw2 = 1'b1;
      align1(50);
      sw2 = 1'b0;
      repeat (P1) tick();
      for (int g = 0; g < 12; g++) begin
         mode = $urandom_range(0, 2);
         for (int c = 0; c < P1; c++) begin
            if (mode == 1) sigdin = ~sigdin;
            else if (mode == 2 && $urandom_range(0, 3) == 0) sigdin = ~sigdin;
            if ($urandom_range(0, 149) == 0) sw2 = ~sw2;
            tick();
         end
      end
      // reset landing on the latch edge of a gate with a nonzero count
      align1(0);
      for (int c = 0; c < 80; c++) begin
         sigdin = ~sigdin;
         tick();
      end
      sigdin = 1'b0;
      align1(G1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (3) begin
         sigdin = 1'b1; repeat (4) tick();
         sigdin = 1'b0; repeat (4) tick();
      end
      repeat (2 * P1 + 10) tick();
   endtask

   task automatic drive2();
      q2.push_back(make_exp(123, 1'b0));
      q2.push_back(make_exp(10000, 1'b0));
      q2.push_back(make_exp(0, 1'b0));
      rst2 = 1'b1;
      repeat (3) tick();
      rst2 = 1'b0;
      for (int m = 0; m < 3 * P2 + 5; m++) begin
         sigdin2 = d2(m);
         tick();
      end
   endtask

   initial begin
      fork
         drive1();
         drive2();
      join
      repeat (3) tick();
      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
